key_space_dispatcher: RTL and testbench
=======================================

Name: key_space_dispatcher

Overview:
- Upstream feeder for the parallel RC4 decryption cores.
- Splits the secret-key space across CORES cores, interleaved: core i tests keys i, i+CORES, i+2·CORES, …
- Hands each core its next key on request and tracks which key each core is currently testing.
- Collects each core's valid/invalid verdict; latches the winning key and core index, or flags that the whole space was searched with no hit.

Parameters:
- CORES, 4, number of decryption cores served (1..16).
- KEY_WIDTH, 24, width of the secret key.
- KEY_MAX, 24'h3FFFFF, highest key searched, inclusive; the top 2 bits of the key space are always zero.

Ports:
- clk  in  1  system clock (CLOCK_50 at top level).
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a search (honoured in IDLE, FOUND or EXHAUSTED).
- core_req  in  CORES  bit i = core i ready for a new key (level or pulse).
- core_key_valid  out  CORES  bit i pulses one cycle when core_key slice i carries a new key (drives new_key_available).
- core_key  out  CORES*KEY_WIDTH  slice i = key given to core i; held until that core's next issue.
- core_done  in  CORES  bit i pulses one cycle when core i finishes checking its key.
- core_hit  in  CORES  bit i is sampled together with core_done[i]; 1 = message valid.
- busy  out  1  high in RUN.
- found  out  1  high in FOUND.
- exhausted  out  1  high in EXHAUSTED.
- found_key  out  KEY_WIDTH  winning key, valid while found=1.
- found_core  out  4  index of the winning core.
- stop_cores  out  1  high in FOUND; tells all cores to abandon work.

Behaviour:
- Reset (asynchronous, any time, including mid-search):
  - State IDLE.
  - All outputs 0, all core_key slices 0.
  - All per-core counters and outstanding/done flags cleared.
- States: IDLE, RUN, FOUND, EXHAUSTED.
- Per-core registers:
  - next_key[i], KEY_WIDTH+1 bits wide so it cannot wrap past KEY_MAX.
  - key_under_test[i].
  - outstanding[i] (key issued, verdict pending).
  - spent[i] (no keys left).
- IDLE/FOUND/EXHAUSTED + start:
  - next_key[i] <= i; outstanding and spent cleared; found, exhausted, stop_cores cleared.
  - Go to RUN next cycle.
  - Any core with i > KEY_MAX is marked spent at start.
- RUN, key issue, evaluated independently per core every cycle:
  - Condition: core_req[i]=1, outstanding[i]=0, spent[i]=0.
  - If next_key[i] <= KEY_MAX: core_key[i] and key_under_test[i] <= next_key[i]; next_key[i] += CORES; outstanding[i] <= 1; core_key_valid[i] pulses the following cycle. Latency from req to valid is 1 cycle.
  - Else: spent[i] <= 1 and no pulse.
  - core_req while outstanding is ignored, so at most one key is in flight per core.
- RUN, verdict:
  - core_done[i] with outstanding[i]=1 clears outstanding[i].
  - core_done without an outstanding key is ignored.
  - If core_hit[i]=1: found_key <= key_under_test[i], found_core <= i, go to FOUND.
  - Several hits in the same cycle: the lowest index wins.
  - A hit in the same cycle as a key issue to another core: the hit takes priority and the issue is suppressed (no valid pulse).
  - core_done[i] and core_req[i] in the same cycle: the release happens this cycle; the new issue is evaluated next cycle.
- RUN -> EXHAUSTED when every spent[i]=1 and every outstanding[i]=0, with no hit that cycle. No further issues.
- FOUND:
  - found=1, stop_cores=1; found_key and found_core frozen.
  - core_done and core_req are ignored.
- EXHAUSTED: exhausted=1; inputs ignored except start.
- start while in RUN is ignored.
- The last key issued is exactly KEY_MAX (whichever core owns KEY_MAX mod CORES). Every key in 0..KEY_MAX is issued exactly once per search.

Test Plan:
- Reset, start, all four cores request simultaneously -> next cycle core_key_valid=4'b1111; keys 0,1,2,3. Core 2 done without hit then requests again -> core 2 receives key 6.
- CORES=4, KEY_MAX=9, cores always request and report core_hit=0 -> keys issued: core0 {0,4,8}, core1 {1,5,9}, core2 {2,6}, core3 {3,7}. exhausted=1 one cycle after the last done; found=0.
- Hit on core 1 testing key 5 -> found=1, found_key=5, found_core=1, stop_cores=1. Later core_done/core_req produce no change and no valid pulses.
- Simultaneous core_hit on cores 3 and 1 -> found_core=1, with that core's key_under_test.
- reset_n low mid-RUN with keys outstanding -> all outputs 0 immediately (asynchronously). A fresh start restarts from keys 0..3.
- start during RUN is ignored. start after FOUND clears found and restarts at keys 0..CORES-1. core_req while outstanding produces no pulse.

Source files
------------

// File: rtl/key_space_dispatcher.sv
// Key-space dispatcher for the parallel RC4 decryption cores.
// The key space 0..KEY_MAX is interleaved across CORES cores (core i tests
// i, i+CORES, ...). Each core is handed its next key on request, its verdict
// is collected, and the first valid key (lowest core index on a tie) is
// latched. If the whole space is searched without a hit, exhausted is raised.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   start               one-cycle pulse, starts a search from IDLE/FOUND/EXHAUSTED
//   core_req[i]         core i ready for a new key
//   core_key_valid[i]   one-cycle pulse: core_key slice i carries a new key
//   core_key            CORES slices of KEY_WIDTH bits, held until next issue
//   core_done[i]        core i finished its current key
//   core_hit[i]         sampled with core_done[i]; 1 = key decrypts validly
//   busy/found/exhausted  state flags (RUN/FOUND/EXHAUSTED)
//   found_key/found_core  winning key and core index, valid while found=1
//   stop_cores          tells all cores to abandon work (high in FOUND)
module key_space_dispatcher #(
    parameter int unsigned           CORES     = 4,
    parameter int unsigned           KEY_WIDTH = 24,
    parameter logic [KEY_WIDTH-1:0]  KEY_MAX   = KEY_WIDTH'(24'h3FFFFF)
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        start,
    input  logic [CORES-1:0]            core_req,
    output logic [CORES-1:0]            core_key_valid,
    output logic [CORES*KEY_WIDTH-1:0]  core_key,
    input  logic [CORES-1:0]            core_done,
    input  logic [CORES-1:0]            core_hit,
    output logic                        busy,
    output logic                        found,
    output logic                        exhausted,
    output logic [KEY_WIDTH-1:0]        found_key,
    output logic [3:0]                  found_core,
    output logic                        stop_cores
);

    // One extra bit so next_key can step past KEY_MAX without wrapping.
    localparam int unsigned NW = KEY_WIDTH + 1;
    localparam logic [NW-1:0] KEY_MAX_EXT = NW'(KEY_MAX);
    localparam logic [NW-1:0] STEP        = NW'(CORES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FOUND,
        ST_EXHAUSTED
    } state_t;

    state_t                      state_q;
    logic [NW-1:0]               next_key_q [CORES];
    logic [KEY_WIDTH-1:0]        kut_q      [CORES];
    logic [CORES-1:0]            outstanding_q;
    logic [CORES-1:0]            spent_q;
    logic [CORES-1:0]            core_key_valid_q;
    logic [CORES*KEY_WIDTH-1:0]  core_key_q;
    logic                        busy_q;
    logic                        found_q;
    logic                        exhausted_q;
    logic                        stop_cores_q;
    logic [KEY_WIDTH-1:0]        found_key_q;
    logic [3:0]                  found_core_q;

    logic [CORES-1:0]            done_c;
    logic [CORES-1:0]            hit_c;
    logic                        hit_any_c;
    logic [3:0]                  hit_idx_c;
    logic [KEY_WIDTH-1:0]        hit_key_c;
    logic [CORES-1:0]            elig_c;
    logic [CORES-1:0]            issue_c;
    logic [CORES-1:0]            outstanding_d;
    logic [CORES-1:0]            spent_d;
    logic [CORES-1:0]            spent_init_c;
    logic                        all_done_c;

    // Verdict collection, lowest-index hit selection, issue decisions and
    // the exhaustion test, all evaluated on this cycle's inputs.
    always_comb begin
        done_c    = core_done & outstanding_q;
        hit_c     = done_c & core_hit;
        hit_any_c = |hit_c;
        hit_idx_c = '0;
        hit_key_c = '0;
        for (int i = CORES - 1; i >= 0; i--) begin
            if (hit_c[i]) begin
                hit_idx_c = 4'(i);
                hit_key_c = kut_q[i];
            end
        end

        // A hit anywhere suppresses every issue in the same cycle.
        elig_c  = hit_any_c ? '0 : (core_req & ~outstanding_q & ~spent_q);
        issue_c = '0;
        spent_d = spent_q;
        for (int i = 0; i < CORES; i++) begin
            if (elig_c[i]) begin
                if (next_key_q[i] <= KEY_MAX_EXT) begin
                    issue_c[i] = 1'b1;
                    // Mark spent as soon as the last key leaves, so exhaustion
                    // is seen on the final verdict rather than a later request.
                    spent_d[i] = (next_key_q[i] + STEP) > KEY_MAX_EXT;
                end else begin
                    spent_d[i] = 1'b1;
                end
            end
        end
        outstanding_d = (outstanding_q & ~done_c) | issue_c;
        all_done_c    = (&spent_d) && !(|outstanding_d) && !hit_any_c;

        spent_init_c = '0;
        for (int i = 0; i < CORES; i++) begin
            spent_init_c[i] = NW'(i) > KEY_MAX_EXT;
        end
    end

    // Search state machine and per-core bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q          <= ST_IDLE;
            outstanding_q    <= '0;
            spent_q          <= '0;
            core_key_valid_q <= '0;
            core_key_q       <= '0;
            busy_q           <= 1'b0;
            found_q          <= 1'b0;
            exhausted_q      <= 1'b0;
            stop_cores_q     <= 1'b0;
            found_key_q      <= '0;
            found_core_q     <= '0;
            for (int i = 0; i < CORES; i++) begin
                next_key_q[i] <= '0;
                kut_q[i]      <= '0;
            end
        end else begin
            core_key_valid_q <= '0;
            case (state_q)
                ST_IDLE, ST_FOUND, ST_EXHAUSTED: begin
                    if (start) begin
                        state_q       <= ST_RUN;
                        busy_q        <= 1'b1;
                        found_q       <= 1'b0;
                        exhausted_q   <= 1'b0;
                        stop_cores_q  <= 1'b0;
                        found_key_q   <= '0;
                        found_core_q  <= '0;
                        outstanding_q <= '0;
                        spent_q       <= spent_init_c;
                        for (int i = 0; i < CORES; i++) begin
                            next_key_q[i] <= NW'(i);
                        end
                    end
                end
                ST_RUN: begin
                    if (hit_any_c) begin
                        state_q       <= ST_FOUND;
                        busy_q        <= 1'b0;
                        found_q       <= 1'b1;
                        stop_cores_q  <= 1'b1;
                        found_key_q   <= hit_key_c;
                        found_core_q  <= hit_idx_c;
                        outstanding_q <= outstanding_q & ~done_c;
                    end else begin
                        outstanding_q    <= outstanding_d;
                        spent_q          <= spent_d;
                        core_key_valid_q <= issue_c;
                        for (int i = 0; i < CORES; i++) begin
                            if (issue_c[i]) begin
                                core_key_q[i*KEY_WIDTH +: KEY_WIDTH] <= next_key_q[i][KEY_WIDTH-1:0];
                                kut_q[i]      <= next_key_q[i][KEY_WIDTH-1:0];
                                next_key_q[i] <= next_key_q[i] + STEP;
                            end
                        end
                        if (all_done_c) begin
                            state_q     <= ST_EXHAUSTED;
                            busy_q      <= 1'b0;
                            exhausted_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign core_key_valid = core_key_valid_q;
    assign core_key       = core_key_q;
    assign busy           = busy_q;
    assign found          = found_q;
    assign exhausted      = exhausted_q;
    assign stop_cores     = stop_cores_q;
    assign found_key      = found_key_q;
    assign found_core     = found_core_q;

endmodule

// File: tb/tb_key_space_dispatcher.sv
// Bench for key_space_dispatcher (CORES=4, KEY_MAX=9): a vector table drives
// one cycle per row; expected key issues go into a scoreboard queue and are
// popped as core_key_valid pulses appear. Hand-written steps cover the
// asynchronous mid-search reset and the restart that follows.
module tb_key_space_dispatcher;

    localparam int unsigned CORES = 4;
    localparam int unsigned KW    = 24;

    logic                 clk;
    logic                 reset_n;
    logic                 start;
    logic [CORES-1:0]     core_req;
    logic [CORES-1:0]     core_key_valid;
    logic [CORES*KW-1:0]  core_key;
    logic [CORES-1:0]     core_done;
    logic [CORES-1:0]     core_hit;
    logic                 busy;
    logic                 found;
    logic                 exhausted;
    logic [KW-1:0]        found_key;
    logic [3:0]           found_core;
    logic                 stop_cores;

    key_space_dispatcher #(
        .CORES     (CORES),
        .KEY_WIDTH (KW),
        .KEY_MAX   (24'd9)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .start          (start),
        .core_req       (core_req),
        .core_key_valid (core_key_valid),
        .core_key       (core_key),
        .core_done      (core_done),
        .core_hit       (core_hit),
        .busy           (busy),
        .found          (found),
        .exhausted      (exhausted),
        .found_key      (found_key),
        .found_core     (found_core),
        .stop_cores     (stop_cores)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic                start;
        logic [3:0]          req;
        logic [3:0]          done;
        logic [3:0]          hit;
        logic [3:0]          ev;
        logic [3:0][KW-1:0]  keys;
        logic                busy;
        logic                found;
        logic                exh;
        logic [KW-1:0]       fkey;
        logic [3:0]          fcore;
    } vec_t;

    typedef struct packed {
        logic [3:0]    core;
        logic [KW-1:0] key;
    } sb_t;

    vec_t vecs[$];
    sb_t  sbq[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(input logic st, input logic [3:0] req, input logic [3:0] done,
                                input logic [3:0] hit, input logic [3:0] ev,
                                input int k0, input int k1, input int k2, input int k3,
                                input logic b, input logic f, input logic e,
                                input int fk, input int fc);
        vec_t v;
        v.start   = st;
        v.req     = req;
        v.done    = done;
        v.hit     = hit;
        v.ev      = ev;
        v.keys[0] = KW'(k0);
        v.keys[1] = KW'(k1);
        v.keys[2] = KW'(k2);
        v.keys[3] = KW'(k3);
        v.busy    = b;
        v.found   = f;
        v.exh     = e;
        v.fkey    = KW'(fk);
        v.fcore   = 4'(fc);
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one row for one clock, then compare flags and drain the scoreboard.
    task automatic run_row(input vec_t v, input string tag);
        sb_t e;
        start     = v.start;
        core_req  = v.req;
        core_done = v.done;
        core_hit  = v.hit;
        for (int i = 0; i < CORES; i++) begin
            if (v.ev[i]) sbq.push_back({4'(i), v.keys[i]});
        end
        @(posedge clk);
        #1;
        start     = 1'b0;
        core_req  = '0;
        core_done = '0;
        core_hit  = '0;
        chk({tag, " valid"},     128'(core_key_valid), 128'(v.ev));
        chk({tag, " busy"},      128'(busy),           128'(v.busy));
        chk({tag, " found"},     128'(found),          128'(v.found));
        chk({tag, " stop"},      128'(stop_cores),     128'(v.found));
        chk({tag, " exhausted"}, 128'(exhausted),      128'(v.exh));
        if (v.found) begin
            chk({tag, " found_key"},  128'(found_key),  128'(v.fkey));
            chk({tag, " found_core"}, 128'(found_core), 128'(v.fcore));
        end
        for (int i = 0; i < CORES; i++) begin
            if (core_key_valid[i]) begin
                if (sbq.size() == 0) begin
                    chk({tag, $sformatf(" unexpected issue core%0d", i)}, 128'(1), 128'(0));
                end else begin
                    e = sbq.pop_front();
                    chk({tag, " issue core"}, 128'(i), 128'(e.core));
                    chk({tag, $sformatf(" key core%0d", i)}, 128'(core_key[i*KW +: KW]), 128'(e.key));
                end
            end
        end
        chk({tag, " scoreboard empty"}, 128'(sbq.size()), 128'(0));
        sbq.delete();
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        core_req  = '0;
        core_done = '0;
        core_hit  = '0;

        //              st req     done    hit     ev      k0 k1 k2 k3 b  f  e  fk fc
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 0 start
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'hF,  0, 1, 2, 3, 1, 0, 0, 0, 0)); // 1 first keys
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 2 req while outstanding
        vecs.push_back(mk(0, 4'h4, 4'h4, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 3 done+req same cycle
        vecs.push_back(mk(0, 4'h4, 4'h0, 4'h0, 4'h4,  0, 0, 6, 0, 1, 0, 0, 0, 0)); // 4 core2 gets 6
        vecs.push_back(mk(0, 4'h0, 4'hB, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 5
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'hB,  4, 5, 0, 7, 1, 0, 0, 0, 0)); // 6
        vecs.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 7
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'h3,  8, 9, 0, 0, 1, 0, 0, 0, 0)); // 8 last keys 8,9
        vecs.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 9
        vecs.push_back(mk(0, 4'h0, 4'h2, 4'h0, 4'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0)); // 10 exhausted
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'h0,  0, 0, 0, 0, 0, 0, 1, 0, 0)); // 11 ignored
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 12 restart
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'hF,  0, 1, 2, 3, 1, 0, 0, 0, 0)); // 13
        vecs.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 14
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'hF,  4, 5, 6, 7, 1, 0, 0, 0, 0)); // 15
        vecs.push_back(mk(0, 4'h0, 4'h1, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 16
        vecs.push_back(mk(0, 4'h1, 4'hA, 4'hA, 4'h0,  0, 0, 0, 0, 0, 1, 0, 5, 1)); // 17 hits 1,3 + req0
        vecs.push_back(mk(0, 4'hF, 4'hF, 4'hF, 4'h0,  0, 0, 0, 0, 0, 1, 0, 5, 1)); // 18 frozen
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 19 start from FOUND
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'hF,  0, 1, 2, 3, 1, 0, 0, 0, 0)); // 20
        vecs.push_back(mk(1, 4'h0, 4'h0, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 21 start in RUN
        vecs.push_back(mk(0, 4'h0, 4'hF, 4'h0, 4'h0,  0, 0, 0, 0, 1, 0, 0, 0, 0)); // 22
        vecs.push_back(mk(0, 4'hF, 4'h0, 4'h0, 4'hF,  4, 5, 6, 7, 1, 0, 0, 0, 0)); // 23 no restart

        // Reset state
        #1;
        chk("reset busy",      128'(busy),           128'(0));
        chk("reset found",     128'(found),          128'(0));
        chk("reset exhausted", 128'(exhausted),      128'(0));
        chk("reset valid",     128'(core_key_valid), 128'(0));
        chk("reset core_key",  128'(core_key),       128'(0));
        #11;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < vecs.size(); k++) begin
            run_row(vecs[k], $sformatf("row%0d", k));
        end

        // Asynchronous reset with keys 4..7 outstanding, between clock edges.
        #2;
        reset_n = 1'b0;
        #1;
        chk("async rst busy",     128'(busy),           128'(0));
        chk("async rst core_key", 128'(core_key),       128'(0));
        chk("async rst valid",    128'(core_key_valid), 128'(0));
        chk("async rst stop",     128'(stop_cores),     128'(0));
        #2;
        reset_n = 1'b1;
        run_row(mk(0, 4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "post-rst idle req");
        run_row(mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 0, 0, 0, 0), "post-rst start");
        run_row(mk(0, 4'hF, 4'h0, 4'h0, 4'hF, 0, 1, 2, 3, 1, 0, 0, 0, 0), "post-rst keys");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
